fp_mul_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 23 ++
 rtl/mant_iter_mul.sv | 57 +++++
 rtl/fp_mul_seq.sv | 196 +++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 multiply path.
// Holds the operand layout and the sequencer state encoding.
package fp_pkg;

  localparam int          FP_BIAS = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/mant_iter_mul.sv
// Iterative shift-add 24x24 mantissa multiplier.
// Retires RADIX_BITS multiplier bits per cycle, LSB first.
module mant_iter_mul #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] product,
  output logic        done
);

  localparam int CYC = 24 / RADIX_BITS;

  logic [47:0] mcand_q;
  logic [47:0] acc_q;
  logic [23:0] mplier_q;
  logic [4:0]  cnt_q;
  logic        run_q;
  logic [47:0] pp;

  // done marks the cycle whose edge retires the last digit
  assign done    = run_q && (cnt_q == 5'(CYC - 1));
  assign product = acc_q;

  always_comb begin
    pp = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      mcand_q  <= {24'd0, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_q + pp;
      mcand_q  <= mcand_q << RADIX_BITS;
      mplier_q <= mplier_q >> RADIX_BITS;
      cnt_q    <= cnt_q + 5'd1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequencer for the binary32 multiply path: screening, mantissa
// multiply, normalizer handoff, RNE rounding and result hold.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid,
  output logic        busy,
  output logic [47:0] norm_product,
  input  logic        norm_eUp,
  input  logic [22:0] norm_mantissa,
  input  logic        norm_L,
  input  logic        norm_G,
  input  logic [22:0] norm_sticky
);

  state_t state_q, state_d;

  fp32_t fa, fb;
  logic  a_zero, a_inf, a_nan;
  logic  b_zero, b_inf, b_nan;
  logic  sgn, nan_any, inf_any, special;
  logic  accept, start, mul_done;

  logic [31:0] spec_res;
  logic        spec_inv;
  logic [9:0]  esum;

  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [22:0]        mant_q;
  logic               l_q, g_q, s_q;
  logic [31:0]        result_q;
  logic               ovf_q, unf_q, inv_q;

  logic              up;
  logic [23:0]       msum;
  logic signed [9:0] efin;
  logic [22:0]       mfin;
  logic              e_ovf, e_unf;

  assign fa = op_a;
  assign fb = op_b;

  assign a_zero = (fa.exp == 8'd0);
  assign b_zero = (fb.exp == 8'd0);
  assign a_inf  = (fa.exp == 8'hFF) && (fa.frac == '0);
  assign b_inf  = (fb.exp == 8'hFF) && (fb.frac == '0);
  assign a_nan  = (fa.exp == 8'hFF) && (fa.frac != '0);
  assign b_nan  = (fb.exp == 8'hFF) && (fb.frac != '0);

  assign sgn     = fa.sign ^ fb.sign;
  assign nan_any = a_nan | b_nan | (a_inf & b_zero)
                 | (a_zero & b_inf);
  assign inf_any = (a_inf | b_inf) & ~nan_any;
  assign special = a_nan | b_nan | a_inf | b_inf
                 | a_zero | b_zero;

  assign accept = in_valid && (state_q == IDLE);
  assign start  = accept && !special;

  assign esum = {2'b00, fa.exp} + {2'b00, fb.exp}
              - 10'(FP_BIAS);

  always_comb begin
    spec_res = '0;
    spec_inv = 1'b0;
    unique case (1'b1)
      nan_any: begin
        spec_res = QNAN;
        spec_inv = 1'b1;
      end
      inf_any: spec_res = {sgn, 8'hFF, 23'd0};
      default: spec_res = {sgn, 31'd0};
    endcase
  end

  mant_iter_mul #(
    .RADIX_BITS (RADIX_BITS)
  ) u_mul (
    .clk     (clk),
    .rst_n   (n_rst),
    .start   (start),
    .a       ({1'b1, fa.frac}),
    .b       ({1'b1, fb.frac}),
    .product (norm_product),
    .done    (mul_done)
  );

  // exp_q is two's complement; range tests use the sign bit
  always_comb begin
    up    = g_q & (l_q | s_q);
    msum  = {1'b0, mant_q} + {23'd0, up};
    efin  = exp_q + {9'd0, msum[23]};
    mfin  = msum[23] ? 23'd0 : msum[22:0];
    e_ovf = !efin[9] && (efin[8:0] >= 9'(EXP_MAX));
    e_unf = efin[9] || (efin == '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = special ? DONE : MULT;
      MULT:  if (mul_done) state_d = NORM;
      NORM:  state_d = ROUND;
      ROUND: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      l_q      <= 1'b0;
      g_q      <= 1'b0;
      s_q      <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sign_q <= sgn;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            inv_q  <= 1'b0;
            if (special) begin
              result_q <= spec_res;
              inv_q    <= spec_inv;
            end else begin
              exp_q <= esum;
            end
          end
        end
        NORM: begin
          mant_q <= norm_mantissa;
          l_q    <= norm_L;
          g_q    <= norm_G;
          s_q    <= |norm_sticky;
          exp_q  <= exp_q + {9'd0, norm_eUp};
        end
        ROUND: begin
          exp_q <= efin;
          if (e_ovf) begin
            result_q <= {sign_q, 8'hFF, 23'd0};
            ovf_q    <= 1'b1;
          end else if (e_unf) begin
            result_q <= {sign_q, 31'd0};
            unf_q    <= 1'b1;
          end else begin
            result_q <= {sign_q, efin[7:0], mfin};
          end
        end
        DONE: begin
          if (out_ready) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            inv_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq with a behavioural normalizer and a
// queue of expected results.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow, underflow, invalid;
  logic        busy;
  logic [47:0] norm_product;
  logic        norm_eUp;
  logic [22:0] norm_mantissa;
  logic        norm_L, norm_G;
  logic [22:0] norm_sticky;

  typedef struct packed {
    logic [31:0] r;
    logic [2:0]  f;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_mul_seq #(.RADIX_BITS(1)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .overflow      (overflow),
    .underflow     (underflow),
    .invalid       (invalid),
    .busy          (busy),
    .norm_product  (norm_product),
    .norm_eUp      (norm_eUp),
    .norm_mantissa (norm_mantissa),
    .norm_L        (norm_L),
    .norm_G        (norm_G),
    .norm_sticky   (norm_sticky)
  );

  // external normalizer model
  always_comb begin
    if (norm_product[47]) begin
      norm_eUp      = 1'b1;
      norm_mantissa = norm_product[46:24];
      norm_G        = norm_product[23];
      norm_sticky   = norm_product[22:0];
    end else begin
      norm_eUp      = 1'b0;
      norm_mantissa = norm_product[45:23];
      norm_G        = norm_product[22];
      norm_sticky   = {norm_product[21:0], 1'b0};
    end
    norm_L = norm_mantissa[0];
  end

  task automatic chk(input string tag,
                     input logic [47:0] got,
                     input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b);
    int w;
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 48'(w < 100), 48'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] er,
                        input logic [2:0]  ef,
                        input int          lat,
                        input bit          hold);
    int   n;
    exp_t e;
    out_ready = !hold;
    sb.push_back('{r: er, f: ef});
    issue(a, b);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 48'(n), 48'(lat));
    e = sb.pop_front();
    chk("result", 48'(result), 48'(e.r));
    chk("flags", 48'({overflow, underflow, invalid}),
        48'(e.f));
    if (hold) begin
      op_a     = 32'h40000000;
      op_b     = 32'h40000000;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        chk("hold_res", 48'(result), 48'(e.r));
        chk("hold_flg", 48'({overflow, underflow, invalid}),
            48'(e.f));
        chk("hold_rdy", 48'({in_ready, out_valid}), 48'b01);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("post_xfer", 48'({in_ready, out_valid, busy}),
        48'b100);
    chk("post_flg", 48'({overflow, underflow, invalid}),
        48'd0);
  endtask

  initial begin
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_a      = '0;
    op_b      = '0;
    #1;
    chk("rst_ctl", 48'({in_ready, out_valid, busy}), 48'b100);
    chk("rst_res", 48'(result), 48'd0);
    chk("rst_flg", 48'({overflow, underflow, invalid}), 48'd0);
    chk("rst_np", norm_product, 48'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 0);
    run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 0);
    run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 26, 0);
    run_op(32'h3F800001, 32'h3F7FFFFF, 32'h3F800000, 3'b000, 26, 0);
    run_op(32'hBFC00000, 32'h40000000, 32'hC0400000, 3'b000, 26, 0);
    run_op(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100, 26, 0);
    run_op(32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 26, 0);
    run_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 0, 0);
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 0, 0);
    run_op(32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 0, 0);
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, 0, 0);
    run_op(32'h00000001, 32'h3F800000, 32'h00000000, 3'b000, 0, 0);
    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 1);
    run_op(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100, 26, 1);

    // abort mid-multiply
    sb.push_back('{r: 32'h40400000, f: 3'b000});
    issue(32'h3FC00000, 32'h40000000);
    repeat (5) @(posedge clk);
    #2 n_rst = 1'b0;
    sb.delete();
    #1;
    chk("abort_ctl", 48'({in_ready, out_valid, busy}), 48'b100);
    chk("abort_res", 48'(result), 48'd0);
    chk("abort_np", norm_product, 48'd0);
    @(negedge clk);
    n_rst = 1'b1;
    run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
